// File: rtl/demux1to8_buf_pkg.sv
// Shared lane constants and select decode for the registered 1-to-8 demux.
// Lane count and select width are fixed by the multiplier's eight partial-product consumers.
package demux1to8_buf_pkg;

  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [N_LANES-1:0] lane_vec_t;

  function automatic lane_vec_t lane_onehot(input sel_t sel);
    lane_onehot      = '0;
    lane_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/demux1to8_buf_if.sv
// Input stream plus eight output lanes of the demux; lane k data is o[k*W +: W].
// The slave side is the demux itself, the master side the source and lane consumers.
interface demux1to8_buf_if #(
  parameter int W = 2
);
  import demux1to8_buf_pkg::*;

  sel_t               s;
  logic [W-1:0]       i;
  logic               i_valid;
  logic               i_ready;
  logic [N_LANES*W-1:0] o;
  lane_vec_t          o_valid;
  lane_vec_t          o_ready;

  modport master (
    output s, i, i_valid, o_ready,
    input  i_ready, o, o_valid
  );

  modport slave (
    input  s, i, i_valid, o_ready,
    output i_ready, o, o_valid
  );

endinterface

// File: rtl/demux1to8_buf_lane_slot.sv
// One-entry lane holding register; loads in 1 cycle, may drain and reload on the same edge.
// Backpressure: word and full flag hold while the consumer withholds ready_in.
module demux_lane_slot #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] di,
  input  logic         ready_in,
  output logic         full,
  output logic [W-1:0] dout
);

  logic drn;

  assign drn = full & ready_in;

  // A load wins over a drain so a reloaded lane never shows a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (ld) begin
      dout <= di;
      full <= 1'b1;
    end else if (drn) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to8_buf.sv
// Registered 1-to-8 demux: each input word lands on lane s one cycle after acceptance.
// Backpressure: i_ready drops only when the addressed lane is full and not draining.
module demux1to8_buf
  import demux1to8_buf_pkg::*;
#(
  parameter int W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  demux1to8_buf_if.slave    bus
);

  lane_vec_t            full;
  lane_vec_t            ld;
  logic [N_LANES*W-1:0] o_flat;
  logic                 acc;

  // Ready looks only at the addressed lane, so a stalled lane blocks nobody else.
  assign bus.i_ready = ~full[bus.s] | bus.o_ready[bus.s];
  assign acc         = bus.i_valid & bus.i_ready;
  assign ld          = acc ? lane_onehot(bus.s) : '0;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    demux_lane_slot #(.W(W)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld       (ld[k]),
      .di       (bus.i),
      .ready_in (bus.o_ready[k]),
      .full     (full[k]),
      .dout     (o_flat[k*W +: W])
    );
  end

  assign bus.o       = o_flat;
  assign bus.o_valid = full;

endmodule

// File: tb/tb_demux1to8_buf.sv
// Directed scenarios plus a randomized run scored against per-lane word queues.
module tb_demux1to8_buf;
  import demux1to8_buf_pkg::*;

  localparam int W = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  demux1to8_buf_if #(.W(W)) bus ();

  demux1to8_buf #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] lane_dat(input int k);
    return bus.o[k*W +: W];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_valid = 1'b1; bus.s = 3'd4; bus.i = 2'b11; bus.o_ready = 8'hFF;
    repeat (3) tick();
    @(negedge clk);
    n_total++;
    if (bus.o_valid !== 8'h00) $display("FAIL reset_valid: got %h want 00", bus.o_valid);
    else n_pass++;
    n_total++;
    if (bus.o !== '0) $display("FAIL reset_data: got %h want 0", bus.o);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.o_valid !== 8'h00) $display("FAIL release_no_emit: got %h want 00", bus.o_valid);
    else n_pass++;
    tick();
    bus.i_valid = 1'b0; bus.o_ready = 8'h00;
    @(negedge clk);
    n_total++;
    if (bus.o_valid !== 8'h10 || lane_dat(4) !== 2'b11)
      $display("FAIL release_first_accept: valid %h data %b want 10 / 11", bus.o_valid, lane_dat(4));
    else n_pass++;
    bus.o_ready = 8'hFF;
    tick();
  endtask

  task automatic test_sweep();
    logic [W-1:0] exp_d;
    bus.o_ready = 8'hFF;
    for (int k = 0; k < N_LANES; k++) begin
      bus.s = sel_t'(k); bus.i = W'(k); bus.i_valid = 1'b1;
      @(negedge clk);
      n_total++;
      if (bus.i_ready !== 1'b1) $display("FAIL sweep_ready lane %0d: got %b want 1", k, bus.i_ready);
      else n_pass++;
      if (k > 0) begin
        exp_d = W'(k - 1);
        n_total++;
        if (bus.o_valid !== (8'h01 << (k - 1)) || lane_dat(k - 1) !== exp_d)
          $display("FAIL sweep_lane %0d: valid %h data %b want %h / %b",
                   k - 1, bus.o_valid, lane_dat(k - 1), 8'h01 << (k - 1), exp_d);
        else n_pass++;
      end
      tick();
    end
    bus.i_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.o_valid !== 8'h80 || lane_dat(7) !== 2'b11)
      $display("FAIL sweep_lane 7: valid %h data %b want 80 / 11", bus.o_valid, lane_dat(7));
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (bus.o_valid !== 8'h00) $display("FAIL sweep_empty: got %h want 00", bus.o_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.o_ready = 8'hF7;
    bus.s = 3'd3; bus.i = 2'b01; bus.i_valid = 1'b1;
    tick();
    bus.i = 2'b10;
    @(negedge clk);
    n_total++;
    if (bus.i_ready !== 1'b0 || lane_dat(3) !== 2'b01 || bus.o_valid[3] !== 1'b1)
      $display("FAIL bp_stall: ready %b data %b valid %b want 0 / 01 / 1",
               bus.i_ready, lane_dat(3), bus.o_valid[3]);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (lane_dat(3) !== 2'b01 || bus.o_valid[3] !== 1'b1)
      $display("FAIL bp_hold: data %b valid %b want 01 / 1", lane_dat(3), bus.o_valid[3]);
    else n_pass++;
    bus.o_ready = 8'hFF;
    #1;
    n_total++;
    if (bus.i_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.i_ready);
    else n_pass++;
    tick();
    bus.i_valid = 1'b0; bus.o_ready = 8'hF7;
    @(negedge clk);
    n_total++;
    if (lane_dat(3) !== 2'b10 || bus.o_valid !== 8'h08)
      $display("FAIL bp_second_word: data %b valid %h want 10 / 08", lane_dat(3), bus.o_valid);
    else n_pass++;
    bus.o_ready = 8'hFF;
    tick();
  endtask

  task automatic test_isolation();
    bus.o_ready = 8'hDF;
    bus.s = 3'd5; bus.i = 2'b10; bus.i_valid = 1'b1;
    tick();
    bus.s = 3'd2; bus.i = 2'b01;
    @(negedge clk);
    n_total++;
    if (bus.i_ready !== 1'b1) $display("FAIL iso_ready_lane2: got %b want 1", bus.i_ready);
    else n_pass++;
    tick();
    bus.s = 3'd6; bus.i = 2'b11;
    @(negedge clk);
    n_total++;
    if (bus.i_ready !== 1'b1 || bus.o_valid !== 8'h24 || lane_dat(2) !== 2'b01)
      $display("FAIL iso_lane2: ready %b valid %h data %b want 1 / 24 / 01",
               bus.i_ready, bus.o_valid, lane_dat(2));
    else n_pass++;
    tick();
    bus.i_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.o_valid !== 8'h60 || lane_dat(6) !== 2'b11 || lane_dat(5) !== 2'b10)
      $display("FAIL iso_lane6: valid %h lane6 %b lane5 %b want 60 / 11 / 10",
               bus.o_valid, lane_dat(6), lane_dat(5));
    else n_pass++;
    bus.o_ready = 8'hFF;
    tick();
  endtask

  task automatic test_drain_reload();
    bus.o_ready = 8'h00;
    bus.s = 3'd1; bus.i = 2'b01; bus.i_valid = 1'b1;
    tick();
    bus.o_ready = 8'h02; bus.i = 2'b11;
    @(negedge clk);
    n_total++;
    if (bus.i_ready !== 1'b1 || bus.o_valid[1] !== 1'b1 || lane_dat(1) !== 2'b01)
      $display("FAIL dr_before: ready %b valid %b data %b want 1 / 1 / 01",
               bus.i_ready, bus.o_valid[1], lane_dat(1));
    else n_pass++;
    tick();
    bus.i_valid = 1'b0; bus.o_ready = 8'h00;
    @(negedge clk);
    n_total++;
    if (bus.o_valid[1] !== 1'b1 || lane_dat(1) !== 2'b11)
      $display("FAIL dr_after: valid %b data %b want 1 / 11", bus.o_valid[1], lane_dat(1));
    else n_pass++;
    bus.o_ready = 8'hFF;
    tick();
  endtask

  task automatic test_async_reset();
    bus.o_ready = 8'h00;
    bus.s = 3'd0; bus.i = 2'b10; bus.i_valid = 1'b1;
    tick();
    bus.s = 3'd7; bus.i = 2'b01;
    tick();
    bus.i_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.o_valid !== 8'h81) $display("FAIL ar_loaded: got %h want 81", bus.o_valid);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.o_valid !== 8'h00 || bus.o !== '0)
      $display("FAIL ar_immediate: valid %h data %h want 00 / 0", bus.o_valid, bus.o);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_total++;
    if (bus.o_valid !== 8'h00) $display("FAIL ar_after_release: got %h want 00", bus.o_valid);
    else n_pass++;
    bus.o_ready = 8'hFF;
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] q [N_LANES][$];
    lane_vec_t    exp_v;
    logic         exp_rdy;
    int           sent = 0;
    int           rcvd = 0;
    int           bad  = 0;
    for (int c = 0; c < 400; c++) begin
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.s       = sel_t'($urandom_range(0, N_LANES - 1));
      bus.i       = W'($urandom);
      for (int k = 0; k < N_LANES; k++) bus.o_ready[k] = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      exp_rdy = (q[bus.s].size() == 0) || bus.o_ready[bus.s];
      n_total++;
      if (bus.i_ready !== exp_rdy) $display("FAIL rnd_ready cyc %0d: got %b want %b", c, bus.i_ready, exp_rdy);
      else n_pass++;
      for (int k = 0; k < N_LANES; k++) exp_v[k] = (q[k].size() != 0);
      bad = 0;
      for (int k = 0; k < N_LANES; k++)
        if (exp_v[k] && lane_dat(k) !== q[k][0]) bad++;
      n_total++;
      if (bus.o_valid !== exp_v || bad != 0)
        $display("FAIL rnd_lanes cyc %0d: valid %h want %h, %0d data errors", c, bus.o_valid, exp_v, bad);
      else n_pass++;
      for (int k = 0; k < N_LANES; k++)
        if (bus.o_ready[k] && q[k].size() != 0) begin
          void'(q[k].pop_front());
          rcvd++;
        end
      if (bus.i_valid && exp_rdy) begin
        q[bus.s].push_back(bus.i);
        sent++;
      end
      tick();
    end
    bus.i_valid = 1'b0; bus.o_ready = 8'hFF;
    for (int k = 0; k < N_LANES; k++) rcvd += q[k].size();
    tick();
    @(negedge clk);
    n_total++;
    if (bus.o_valid !== 8'h00 || rcvd != sent)
      $display("FAIL rnd_conservation: valid %h received %0d want 00 / %0d", bus.o_valid, rcvd, sent);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.s = '0; bus.i = '0; bus.i_valid = 1'b0; bus.o_ready = '0;
    test_reset();
    test_sweep();
    test_backpressure();
    test_isolation();
    test_drain_reload();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
